// File: rtl/ex_mem_stage_if.sv
// Signal bundle between the ID/EX side, the writeback stage and the EX/MEM stage.
// The master drives the stage inputs and the slave is the stage itself.
interface ex_mem_stage_if;
    logic        stall;
    logic [3:0]  ctrl_in;
    logic        branch_in;
    logic        jal_in;
    logic        jalr_in;
    logic [2:0]  funct3_in;
    logic        alu_src_in;
    logic [3:0]  alu_op_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] imm_in;
    logic [31:0] pc_in;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  ctrl_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  rd_out;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output stall, ctrl_in, branch_in, jal_in, jalr_in, funct3_in, alu_src_in,
               alu_op_in, rs1_in, rs2_in, rd_in, a_in, b_in, imm_in, pc_in,
               wb_reg_write, wb_rd, wb_data,
        input  ctrl_out, alu_result_out, store_data_out, rd_out, redirect, redirect_pc
    );

    modport slave (
        input  stall, ctrl_in, branch_in, jal_in, jalr_in, funct3_in, alu_src_in,
               alu_op_in, rs1_in, rs2_in, rd_in, a_in, b_in, imm_in, pc_in,
               wb_reg_write, wb_rd, wb_data,
        output ctrl_out, alu_result_out, store_data_out, rd_out, redirect, redirect_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, branch/jump resolution and the EX/MEM
// pipeline register, which captures on the falling clock edge.
module ex_mem_stage (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_stage_if.slave bus
);
    // Handshake: stall=1 holds the stage register and suppresses redirect; there is
    // no valid/ready pair, every non-stalled falling edge accepts one instruction.
    logic        ex_fwd_ok;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic        cond;

    // A load in EX/MEM has no data yet, so it is never a forwarding source.
    assign ex_fwd_ok = bus.ctrl_out[3] & ~bus.ctrl_out[0];

    always_comb begin
        fwd_a = bus.a_in;
        if (bus.rs1_in != 5'd0) begin
            if (ex_fwd_ok && (bus.rd_out == bus.rs1_in))
                fwd_a = bus.alu_result_out;
            else if (bus.wb_reg_write && (bus.wb_rd == bus.rs1_in))
                fwd_a = bus.wb_data;
        end
    end

    always_comb begin
        fwd_b = bus.b_in;
        if (bus.rs2_in != 5'd0) begin
            if (ex_fwd_ok && (bus.rd_out == bus.rs2_in))
                fwd_b = bus.alu_result_out;
            else if (bus.wb_reg_write && (bus.wb_rd == bus.rs2_in))
                fwd_b = bus.wb_data;
        end
    end

    assign op_b = bus.alu_src_in ? bus.imm_in : fwd_b;

    always_comb begin
        case (bus.alu_op_in)
            4'h1:    alu_res = fwd_a - op_b;
            4'h2:    alu_res = fwd_a & op_b;
            4'h3:    alu_res = fwd_a | op_b;
            4'h4:    alu_res = fwd_a ^ op_b;
            4'h5:    alu_res = fwd_a << op_b[4:0];
            4'h6:    alu_res = fwd_a >> op_b[4:0];
            4'h7:    alu_res = $unsigned($signed(fwd_a) >>> op_b[4:0]);
            4'h8:    alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            4'h9:    alu_res = {31'd0, fwd_a < op_b};
            4'hA:    alu_res = op_b;
            default: alu_res = fwd_a + op_b;
        endcase
    end

    always_comb begin
        case (bus.funct3_in)
            3'b000:  cond = (fwd_a == fwd_b);
            3'b001:  cond = (fwd_a != fwd_b);
            3'b100:  cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  cond = (fwd_a < fwd_b);
            3'b111:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign pc_plus4  = bus.pc_in + 32'd4;
    assign br_target = bus.pc_in + bus.imm_in;
    assign jalr_sum  = fwd_a + bus.imm_in;
    assign target    = bus.jalr_in ? {jalr_sum[31:1], 1'b0} : br_target;

    assign bus.redirect    = rst_n & ~bus.stall &
                             (bus.jal_in | bus.jalr_in | (bus.branch_in & cond));
    assign bus.redirect_pc = bus.redirect ? target : 32'd0;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ctrl_out       <= 4'd0;
            bus.alu_result_out <= 32'd0;
            bus.store_data_out <= 32'd0;
            bus.rd_out         <= 5'd0;
        end else if (!bus.stall) begin
            // Conditional branches leave a bubble; jumps write the link address.
            bus.ctrl_out       <= bus.branch_in ? 4'd0 : bus.ctrl_in;
            bus.alu_result_out <= (bus.jal_in | bus.jalr_in) ? pc_plus4 : alu_res;
            bus.store_data_out <= fwd_b;
            bus.rd_out         <= bus.rd_in;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector bench for ex_mem_stage: a table of chained instructions plus
// hand-written stall and reset sequences.
module tb_ex_mem_stage;
    logic clk;
    logic rst_n;
    ex_mem_stage_if bus ();

    ex_mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic        src;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic [3:0]  e_ctrl;
        logic [31:0] e_alu;
        logic [31:0] e_store;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[$];
    int   chk_cnt;
    int   pass_cnt;

    function automatic void add_vec(
        logic [3:0] ctrl, logic br, logic jal, logic jalr, logic [2:0] f3, logic src,
        logic [3:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
        logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc,
        logic wb_we, logic [4:0] wb_rd, logic [31:0] wb_data,
        logic e_redir, logic [31:0] e_rpc, logic [3:0] e_ctrl, logic [31:0] e_alu,
        logic [31:0] e_store, logic [4:0] e_rd);
        vec_t v;
        v.ctrl = ctrl; v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.src = src;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.a = a; v.b = b;
        v.imm = imm; v.pc = pc; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_ctrl = e_ctrl; v.e_alu = e_alu;
        v.e_store = e_store; v.e_rd = e_rd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.ctrl_in = v.ctrl;   bus.branch_in = v.br;  bus.jal_in = v.jal;
        bus.jalr_in = v.jalr;   bus.funct3_in = v.f3;  bus.alu_src_in = v.src;
        bus.alu_op_in = v.op;   bus.rs1_in = v.rs1;    bus.rs2_in = v.rs2;
        bus.rd_in = v.rd;       bus.a_in = v.a;        bus.b_in = v.b;
        bus.imm_in = v.imm;     bus.pc_in = v.pc;      bus.wb_reg_write = v.wb_we;
        bus.wb_rd = v.wb_rd;    bus.wb_data = v.wb_data;
    endtask

    task automatic check_regs(input string tag, input logic [3:0] c, input logic [31:0] alu,
                              input logic [31:0] st, input logic [4:0] rd);
        check({tag, ".ctrl_out"}, {28'd0, bus.ctrl_out}, {28'd0, c});
        check({tag, ".alu_result_out"}, bus.alu_result_out, alu);
        check({tag, ".store_data_out"}, bus.store_data_out, st);
        check({tag, ".rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
    endtask

    initial begin
        vec_t v;
        chk_cnt  = 0;
        pass_cnt = 0;
        //       ctrl     br jal jalr f3      src op    rs1 rs2 rd  a             b             imm           pc         we wbrd wbdata   redir rpc         ctrl     alu           store         rd
        add_vec(4'b1000, 0, 0, 0, 3'b000, 1, 4'h0, 5,  6,  1,  32'd60,       32'd3,        32'd40,       32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'd100,      32'd3,        1);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 0, 4'h0, 1,  2,  3,  32'd5,        32'd7,        32'd0,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'd107,      32'd7,        3);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 0, 4'h1, 3,  9,  0,  32'd1,        32'd7,        32'd0,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'd100,      32'd7,        0);
        add_vec(4'b1101, 0, 0, 0, 3'b000, 0, 4'h4, 0,  0,  4,  32'd11,       32'd22,       32'd0,        32'd0,     1, 0,  32'd999, 0, 32'h0,   4'b1101, 32'd29,       32'd22,       4);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 0, 4'h0, 7,  4,  5,  32'd10,       32'd1,        32'd0,        32'd0,     1, 4,  32'd9,   0, 32'h0,   4'b1000, 32'd19,       32'd9,        5);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 1, 4'h5, 5,  8,  6,  32'd0,        32'hAAAA,     32'h23,       32'd0,     1, 5,  32'd77,  0, 32'h0,   4'b1000, 32'd152,      32'hAAAA,     6);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 1, 4'h7, 2,  1,  7,  32'h80000000, 32'd5,        32'd4,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'hF8000000, 32'd5,        7);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 1, 4'h6, 7,  0,  8,  32'd0,        32'd0,        32'd4,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'h0F800000, 32'd0,        8);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 0, 4'h8, 1,  2,  9,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'd1,        32'd1,        9);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 0, 4'h9, 1,  2,  10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'd0,        32'd1,        10);
        add_vec(4'b1000, 0, 0, 0, 3'b000, 1, 4'hA, 0,  3,  11, 32'd0,        32'h55,       32'h12345678, 32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b1000, 32'h12345678, 32'h55,       11);
        add_vec(4'b0010, 0, 0, 0, 3'b000, 0, 4'hB, 1,  2,  12, 32'd2,        32'd3,        32'd0,        32'd0,     0, 0,  32'd0,   0, 32'h0,   4'b0010, 32'd5,        32'd3,        12);
        add_vec(4'b0000, 1, 0, 0, 3'b001, 0, 4'h0, 1,  2,  0,  32'd1,        32'd2,        32'hFFFFFFF8, 32'h40,    0, 0,  32'd0,   1, 32'h38,  4'b0000, 32'd3,        32'd2,        0);
        add_vec(4'b1000, 1, 0, 0, 3'b000, 0, 4'h0, 1,  2,  0,  32'd1,        32'd2,        32'hFFFFFFF8, 32'h40,    0, 0,  32'd0,   0, 32'h0,   4'b0000, 32'd3,        32'd2,        0);
        add_vec(4'b0000, 1, 0, 0, 3'b100, 0, 4'h0, 1,  2,  0,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,    0, 0,  32'd0,   1, 32'h90,  4'b0000, 32'd0,        32'd1,        0);
        add_vec(4'b0000, 1, 0, 0, 3'b110, 0, 4'h0, 1,  2,  0,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,    0, 0,  32'd0,   0, 32'h0,   4'b0000, 32'd0,        32'd1,        0);
        add_vec(4'b0000, 1, 0, 0, 3'b111, 0, 4'h0, 1,  2,  0,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,    0, 0,  32'd0,   1, 32'h90,  4'b0000, 32'd0,        32'd1,        0);
        add_vec(4'b0000, 1, 0, 0, 3'b101, 0, 4'h0, 1,  2,  0,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,    0, 0,  32'd0,   0, 32'h0,   4'b0000, 32'd0,        32'd1,        0);
        add_vec(4'b0000, 1, 0, 0, 3'b010, 0, 4'h0, 1,  2,  0,  32'd5,        32'd5,        32'h10,       32'h80,    0, 0,  32'd0,   0, 32'h0,   4'b0000, 32'd10,       32'd5,        0);
        add_vec(4'b1000, 0, 0, 1, 3'b000, 1, 4'h0, 1,  0,  1,  32'h203,      32'd0,        32'd4,        32'h100,   0, 0,  32'd0,   1, 32'h206, 4'b1000, 32'h104,      32'd0,        1);
        add_vec(4'b1000, 0, 1, 0, 3'b000, 0, 4'h0, 0,  1,  2,  32'd0,        32'd0,        32'h20,       32'h200,   0, 0,  32'd0,   1, 32'h220, 4'b1000, 32'h204,      32'h104,      2);

        // Reset state, with a jump presented so redirect must be held low by reset.
        rst_n = 1'b0;
        bus.stall = 1'b0;
        v = vecs[19];
        drive(v);
        #3;
        check_regs("reset", 4'd0, 32'd0, 32'd0, 5'd0);
        check("reset.redirect", {31'd0, bus.redirect}, 32'd0);
        check("reset.redirect_pc", bus.redirect_pc, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (i != 0) begin
                @(posedge clk); #1;
            end
            drive(vecs[i]);
            #1;
            check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, vecs[i].e_redir});
            check({tag, ".redirect_pc"}, bus.redirect_pc, vecs[i].e_rpc);
            @(negedge clk); #1;
            check_regs(tag, vecs[i].e_ctrl, vecs[i].e_alu, vecs[i].e_store, vecs[i].e_rd);
        end

        // Stalled JAL: no redirect, register holds; releasing stall lets it through.
        @(posedge clk); #1;
        v = vecs[20];
        v.pc = 32'h300; v.imm = 32'd8; v.rd = 5'd3; v.rs2 = 5'd0; v.b = 32'd0;
        drive(v);
        bus.stall = 1'b1;
        #1;
        check("stall.redirect", {31'd0, bus.redirect}, 32'd0);
        check("stall.redirect_pc", bus.redirect_pc, 32'd0);
        @(negedge clk); #1;
        check_regs("stall.hold", 4'b1000, 32'h204, 32'h104, 5'd2);
        @(posedge clk); #1;
        bus.stall = 1'b0;
        #1;
        check("unstall.redirect", {31'd0, bus.redirect}, 32'd1);
        check("unstall.redirect_pc", bus.redirect_pc, 32'h308);
        @(negedge clk); #1;
        check_regs("unstall.load", 4'b1000, 32'h304, 32'd0, 5'd3);

        // Asynchronous reset mid-stall, between clock edges.
        @(posedge clk); #1;
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 4'd0, 32'd0, 32'd0, 5'd0);
        bus.stall = 1'b0;
        #1;
        check("rst_held.redirect", {31'd0, bus.redirect}, 32'd0);
        check("rst_held.redirect_pc", bus.redirect_pc, 32'd0);
        @(negedge clk); #1;
        check_regs("rst_held", 4'd0, 32'd0, 32'd0, 5'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; stage register captures on falling edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  memory-side hold; freezes the stage register.
REQ-005 ctrl_in  in  4  {reg_write, mem_to_reg, mem_write, mem_read} from ID/EX.
REQ-006 branch_in  in  1  conditional branch.
REQ-007 jal_in  in  1  JAL.
REQ-008 jalr_in  in  1  JALR.
REQ-009 funct3_in  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 alu_src_in  in  1  1: operand B = imm_in.
REQ-011 alu_op_in  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A pass-B; B-F ADD.
REQ-012 rs1_in  in  5  source register 1 index.
REQ-013 rs2_in  in  5  source register 2 index.
REQ-014 rd_in  in  5  destination index.
REQ-015 a_in  in  32  register-file value of rs1.
REQ-016 b_in  in  32  register-file value of rs2.
REQ-017 imm_in  in  32  sign-extended immediate.
REQ-018 pc_in  in  32  instruction PC.
REQ-019 wb_reg_write  in  1  writeback-stage write enable.
REQ-020 wb_rd  in  5  writeback destination.
REQ-021 wb_data  in  32  writeback value.
REQ-022 ctrl_out  out  4  registered ctrl_in.
REQ-023 alu_result_out  out  32  registered ALU result, or PC+4 for JAL/JALR.
REQ-024 store_data_out  out  32  registered forwarded rs2 value.
REQ-025 rd_out  out  5  registered destination.
REQ-026 redirect  out  1  combinational: taken branch/jump, flush IF/ID and ID/EX.
REQ-027 redirect_pc  out  32  combinational target address.

Function
REQ-028 Forwarding per source (index nonzero): match rd_out with ctrl_out reg_write and not mem_read -> alu_result_out; else match wb_rd with wb_reg_write -> wb_data; else register-file value; EX/MEM wins over WB.
REQ-029 Index 0 SHALL never forward; load-use hazards are stalled upstream and not handled here.
REQ-030 Operand B = imm_in when alu_src_in=1, else forwarded rs2; store_data_out always forwarded rs2.
REQ-031 Arithmetic 32-bit, wrap-around, no overflow flag; shifts use B[4:0]; SLT signed, SLTU unsigned, result 0/1.
REQ-032 Branch compare uses forwarded rs1 vs rs2 per funct3_in; funct3 010/011 never taken.
REQ-033 Targets: branch/JAL pc_in+imm_in; JALR (fwd rs1+imm_in) with bit 0 cleared.
REQ-034 redirect = ~stall & (jal_in | jalr_in | (branch_in & condition true)); redirect_pc 0 when redirect=0.
REQ-035 On falling clk with stall=0 the stage register SHALL load all outputs; latency one half-cycle-aligned stage.
REQ-036 With stall=1 all registered outputs hold; redirect forced 0.
REQ-037 Conditional branches SHALL load ctrl_out=0 (bubble); JAL/JALR load ctrl_in with alu_result_out=pc_in+4.

Reset
REQ-038 rst_n=0 SHALL immediately clear ctrl_out, alu_result_out, store_data_out, rd_out to 0, including mid-stall; redirect/redirect_pc 0 while reset held.

Verification
REQ-039 ADD x3,x1,x2 a_in=5 b_in=7, rd_out=x1 reg_write alu_result_out=100 -> result 107 (EX/MEM forward on rs1).
REQ-040 rs2=x4, wb_rd=4 wb_data=9, rd_out=4 with ctrl_out mem_read=1 -> B uses 9, not alu_result_out.
REQ-041 BNE pc_in=0x40 imm_in=-8, a_in=1 b_in=2 -> redirect=1 redirect_pc=0x38, next ctrl_out=0.
REQ-042 JALR pc_in=0x100 a_in=0x203 imm_in=4 -> redirect_pc=0x206, alu_result_out=0x104.
REQ-043 stall=1 during JAL -> redirect=0, outputs hold; stall drop -> redirect=1 and register loads.
REQ-044 rst_n low mid-stall with nonzero outputs -> all outputs 0 without clock edge.
